tetris_input: RTL and testbench

TETRIS_INPUT -- requirements
Module: tetris_input

---
 rtl/tetris_input_pkg.sv | 9 +
 rtl/tetris_input_btn_cond.sv | 119 +++++++++++
 rtl/tetris_input.sv | 38 +++
 tb/tb_tetris_input.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tetris_input_pkg.sv
// tetris_input_pkg: shared button FSM states, button indices and LFSR seed
package tetris_input_pkg;
    typedef enum logic [2:0] {IDLE, DEBOUNCE_P, FIRE, HELD, DEBOUNCE_R} btn_state_t;
    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_SPIN  = 3;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
endpackage

// File: rtl/tetris_input_btn_cond.sv
// btn_cond: synchroniser + debounce/pulse/auto-repeat FSM for one button (repeat built only with TETRIS_AUTOREPEAT_EN)
module btn_cond import tetris_input_pkg::*; #(
    parameter int DEB_CYCLES   = 20000,
    parameter int PULSE_LEN    = 16,
    parameter int REPEAT_DELAY = 6000000,
    parameter int REPEAT_RATE  = 2000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic rep_en,
    input  logic inhibit,
    output logic fire,
    output logic fire_nxt
);
    localparam int DW = $clog2(DEB_CYCLES) > 0 ? $clog2(DEB_CYCLES) : 1;
    localparam int PW = $clog2(PULSE_LEN) > 0 ? $clog2(PULSE_LEN) : 1;
    logic s1, s2;
    btn_state_t state, state_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [PW-1:0] pcnt, pcnt_n;
`ifdef TETRIS_AUTOREPEAT_EN
    localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = $clog2(RMAX) > 0 ? $clog2(RMAX) : 1;
    logic [RW-1:0] hcnt, hcnt_n, thr;
    logic rep, rep_n;
    assign thr = rep ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1);
    // held-time counter and first/later repeat flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            rep  <= 1'b0;
        end else begin
            hcnt <= hcnt_n;
            rep  <= rep_n;
        end
    end
`else
    logic unused_rep;
    assign unused_rep = rep_en | (REPEAT_DELAY < 0) | (REPEAT_RATE < 0);
`endif
    // two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {s2, s1} <= 2'b00;
        else {s2, s1} <= {s1, raw};
    end
    // state and debounce/pulse counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            dcnt  <= '0;
            pcnt  <= '0;
        end else begin
            state <= state_n;
            dcnt  <= dcnt_n;
            pcnt  <= pcnt_n;
        end
    end
    // next state; counters stop at their terminal value, so they never wrap
    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        pcnt_n  = pcnt;
`ifdef TETRIS_AUTOREPEAT_EN
        hcnt_n  = hcnt;
        rep_n   = rep;
`endif
        case (state)
            IDLE: if (s2) begin
                state_n = DEBOUNCE_P;
                dcnt_n  = '0;
            end
            DEBOUNCE_P: begin
                if (!s2) state_n = IDLE;
                else if (dcnt != DW'(DEB_CYCLES - 1)) dcnt_n = dcnt + DW'(1);
                else if (!inhibit) begin
                    state_n = FIRE;
                    pcnt_n  = '0;
`ifdef TETRIS_AUTOREPEAT_EN
                    rep_n   = 1'b0;
`endif
                end
            end
            FIRE: begin
                if (pcnt != PW'(PULSE_LEN - 1)) pcnt_n = pcnt + PW'(1);
                else begin
                    state_n = HELD;
`ifdef TETRIS_AUTOREPEAT_EN
                    hcnt_n  = '0;
`endif
                end
            end
            HELD: begin
                if (!s2) begin
                    state_n = DEBOUNCE_R;
                    dcnt_n  = '0;
                end
`ifdef TETRIS_AUTOREPEAT_EN
                else if (rep_en) begin
                    if (hcnt != thr) hcnt_n = hcnt + RW'(1);
                    else if (!inhibit) begin
                        state_n = FIRE;
                        pcnt_n  = '0;
                        rep_n   = 1'b1;
                    end
                end
`endif
            end
            DEBOUNCE_R: begin
                if (s2) state_n = HELD;
                else if (dcnt != DW'(DEB_CYCLES - 1)) dcnt_n = dcnt + DW'(1);
                else state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    assign fire     = state == FIRE;
    assign fire_nxt = state_n == FIRE;
endmodule

// File: rtl/tetris_input.sv
// tetris_input: four conditioned buttons, Left/Right arbitration and LFSR piece selector (auto-repeat via TETRIS_AUTOREPEAT_EN)
module tetris_input import tetris_input_pkg::*; #(
    parameter int DEB_CYCLES   = 20000,
    parameter int PULSE_LEN    = 16,
    parameter int REPEAT_DELAY = 6000000,
    parameter int REPEAT_RATE  = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    output logic       Left,
    output logic       Right,
    output logic       Down,
    output logic       Spin,
    output logic [1:0] value
);
    logic l_nxt, r_nxt, d_nxt, s_nxt, rise;
    logic [7:0] lfsr;
    btn_cond #(.DEB_CYCLES(DEB_CYCLES), .PULSE_LEN(PULSE_LEN), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_left (
        .clk(clk), .rst(rst), .raw(btn_raw[BTN_LEFT]), .rep_en(1'b1), .inhibit(1'b0), .fire(Left), .fire_nxt(l_nxt));
    btn_cond #(.DEB_CYCLES(DEB_CYCLES), .PULSE_LEN(PULSE_LEN), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_right (
        .clk(clk), .rst(rst), .raw(btn_raw[BTN_RIGHT]), .rep_en(1'b1), .inhibit(l_nxt), .fire(Right), .fire_nxt(r_nxt));
    btn_cond #(.DEB_CYCLES(DEB_CYCLES), .PULSE_LEN(PULSE_LEN), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_down (
        .clk(clk), .rst(rst), .raw(btn_raw[BTN_DOWN]), .rep_en(1'b1), .inhibit(1'b0), .fire(Down), .fire_nxt(d_nxt));
    btn_cond #(.DEB_CYCLES(DEB_CYCLES), .PULSE_LEN(PULSE_LEN), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_spin (
        .clk(clk), .rst(rst), .raw(btn_raw[BTN_SPIN]), .rep_en(1'b0), .inhibit(1'b0), .fire(Spin), .fire_nxt(s_nxt));
    assign rise = (l_nxt & ~Left) | (r_nxt & ~Right) | (d_nxt & ~Down) | (s_nxt & ~Spin);
    // free-running x^8+x^6+x^5+x^4+1 LFSR, recovering from the lock-up state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= LFSR_SEED;
        else lfsr <= lfsr == 8'h00 ? LFSR_SEED : {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    // capture a piece selector whenever any command pulse starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) value <= 2'd0;
        else if (rise) value <= lfsr[1:0];
    end
endmodule

// File: tb/tb_tetris_input.sv
// tb_tetris_input: directed stimulus with a cycle-level behavioural model and literal spot checks
module tb_tetris_input;
    localparam int DEB = 4;
    localparam int PL  = 16;
    localparam int RD  = 40;
    localparam int RR  = 20;
`ifdef TETRIS_AUTOREPEAT_EN
    localparam bit REP_OK = 1'b1;
`else
    localparam bit REP_OK = 1'b0;
`endif
    logic clk;
    logic rst = 1'b1;
    logic [3:0] btn_raw = 4'b0000;
    logic Left, Right, Down, Spin;
    logic [1:0] value;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit h1 [4], h2 [4], acc [4];
    int run [4], rel [4], pulse [4], hold [4], reps [4];
    logic [7:0] m_lfsr;
    logic [1:0] m_value;
    int nrise [4];
    int rlog [4][16];
    int plen [4];
    bit prev [4];

    tetris_input #(.DEB_CYCLES(DEB), .PULSE_LEN(PL), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .Left(Left), .Right(Right), .Down(Down), .Spin(Spin), .value(value));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 4; i++) begin
            h1[i] = 0; h2[i] = 0; acc[i] = 0;
            run[i] = 0; rel[i] = 0; pulse[i] = 0; hold[i] = 0; reps[i] = 0;
        end
        m_lfsr = 8'hA5;
        m_value = 2'd0;
    endtask

    // one clock of the behavioural model: sync delay, press/hold/release rules, arbitration, LFSR
    task automatic step();
        bit s [4];
        bit rise, inh, was;
        int thr;
        rise = 0;
        for (int i = 0; i < 4; i++) begin
            s[i] = h2[i]; h2[i] = h1[i]; h1[i] = btn_raw[i];
        end
        for (int i = 0; i < 4; i++) begin
            inh = (i == 1) && (pulse[0] > 0);
            was = pulse[i] > 0;
            if (!acc[i]) begin
                run[i] = s[i] ? run[i] + 1 : 0;
                if (run[i] > DEB && !inh) begin
                    acc[i] = 1; pulse[i] = PL; reps[i] = 0; rel[i] = 0;
                end
            end else if (pulse[i] > 0) begin
                pulse[i]--; hold[i] = 0;
            end else if (!s[i]) begin
                rel[i]++;
                if (rel[i] > DEB) begin acc[i] = 0; run[i] = 0; end
            end else if (rel[i] > 0) begin
                rel[i] = 0;
            end else if (REP_OK && i != 3) begin
                thr = reps[i] == 0 ? RD : RR;
                if (hold[i] + 1 >= thr) begin
                    if (!inh) begin pulse[i] = PL; reps[i]++; end
                end else hold[i]++;
            end
            if (!was && pulse[i] > 0) rise = 1;
        end
        if (rise) m_value = m_lfsr[1:0];
        m_lfsr = m_lfsr == 8'h00 ? 8'hA5 : {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) mreset();
            else step();
        end
    end

    // per-cycle compare against the model plus pulse bookkeeping
    initial begin
        logic [3:0] o, e;
        for (int i = 0; i < 4; i++) begin nrise[i] = 0; plen[i] = 0; prev[i] = 0; end
        forever begin
            @(negedge clk);
            o = {Spin, Down, Right, Left};
            for (int i = 0; i < 4; i++) e[i] = pulse[i] > 0;
            check("outs", int'(o), int'(e));
            check("value", int'(value), int'(m_value));
            check("lfsr", int'(dut.lfsr), int'(m_lfsr));
            check("left_right_excl", int'(Left & Right), 0);
            for (int i = 0; i < 4; i++) begin
                if (o[i] && !prev[i]) begin
                    if (nrise[i] < 16) rlog[i][nrise[i]] = cyc;
                    nrise[i]++;
                end
                if (!o[i] && prev[i]) plen[i] = cyc - rlog[i][(nrise[i] - 1) % 16];
                prev[i] = o[i];
            end
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    initial begin
        int st, n0, n1, seen_cnt, dup, zero;
        bit seen [256];
        wait_edges(3);
        check("reset_outs", int'({Spin, Down, Right, Left}), 0);
        check("reset_value", int'(value), 0);
        check("reset_lfsr", int'(dut.lfsr), 8'hA5);
        rst = 1'b0;
        check("lfsr_seed", int'(dut.lfsr), 8'hA5);
        wait_edges(1);
        check("lfsr_step1", int'(dut.lfsr), 8'h4A);
        wait_edges(1);
        check("lfsr_step2", int'(dut.lfsr), 8'h95);
        // glitch on Left
        n0 = nrise[0];
        btn_raw[0] = 1'b1;
        wait_edges(3);
        btn_raw[0] = 1'b0;
        wait_edges(20);
        check("glitch_left_rises", nrise[0] - n0, 0);
        // single Down press
        n0 = nrise[2]; st = cyc;
        btn_raw[2] = 1'b1;
        wait_edges(30);
        btn_raw[2] = 1'b0;
        wait_edges(20);
        check("down_rises", nrise[2] - n0, 1);
        check("down_latency", rlog[2][n0] - st, 7);
        check("down_len", plen[2], 16);
        // Right held for auto-repeat
        n0 = nrise[1]; st = cyc;
        btn_raw[1] = 1'b1;
        wait_edges(200);
        btn_raw[1] = 1'b0;
        wait_edges(30);
        check("right_first", rlog[1][n0] - st, 7);
        if (REP_OK) begin
            check("right_rises", nrise[1] - n0, 5);
            check("right_gap1", rlog[1][n0 + 1] - rlog[1][n0], 56);
            check("right_gap2", rlog[1][n0 + 2] - rlog[1][n0 + 1], 36);
        end else begin
            check("right_rises", nrise[1] - n0, 1);
        end
        // Left and Right together
        n0 = nrise[0]; n1 = nrise[1]; st = cyc;
        btn_raw[1:0] = 2'b11;
        wait_edges(30);
        btn_raw[1:0] = 2'b00;
        wait_edges(40);
        check("conf_left_rises", nrise[0] - n0, 1);
        check("conf_right_rises", nrise[1] - n1, 1);
        check("conf_left_t", rlog[0][n0] - st, 7);
        check("conf_right_t", rlog[1][n1] - st, 23);
        check("conf_right_len", plen[1], 16);
        // reset in the middle of a Spin pulse, Spin kept held
        n0 = nrise[3]; st = cyc;
        btn_raw[3] = 1'b1;
        wait_edges(11);
        check("spin_mid", int'(Spin), 1);
        rst = 1'b1;
        #1;
        check("spin_async_drop", int'(Spin), 0);
        wait_edges(3);
        rst = 1'b0;
        st = cyc;
        wait_edges(100);
        check("spin_rises", nrise[3] - n0, 2);
        check("spin_after_rst", rlog[3][n0 + 1] - st, 7);
        btn_raw[3] = 1'b0;
        wait_edges(20);
        // 255 consecutive LFSR states
        for (int i = 0; i < 256; i++) seen[i] = 0;
        dup = 0; zero = 0; seen_cnt = 0;
        for (int i = 0; i < 255; i++) begin
            if (dut.lfsr == 8'h00) zero++;
            if (seen[dut.lfsr]) dup++;
            else seen_cnt++;
            seen[dut.lfsr] = 1;
            wait_edges(1);
        end
        check("lfsr_dups", dup, 0);
        check("lfsr_zero", zero, 0);
        check("lfsr_distinct", seen_cnt, 255);
        rst = 1'b1;
        wait_edges(1);
        check("lfsr_after_rst", int'(dut.lfsr), 8'hA5);
        wait_edges(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
